stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
// PURPOSE
//  Timekeeping datapath for the stopwatch: consumes the one-cycle command pulses issued by the
//  button controller (start/stop, inc, dec, clear) and maintains a 4-digit BCD SS.hh count.
//  The count advances at TICK_HZ while running. Output digits feed the 7-segment display mux.
// PARAMETERS
//  CLK_HZ   100_000_000  input clock frequency, Hz
//  TICK_HZ  100          count rate, Hz; TICK_DIV = CLK_HZ/TICK_HZ, must be an integer >= 2
// PORTS
//  clk         in   1   system clock; the only clock
//  reset       in   1   synchronous, active-high reset
//  start_stop  in   1   pulse: toggles STOPPED<->RUN
//  inc         in   1   pulse: add 1.00 s (STOPPED only)
//  dec         in   1   pulse: subtract 1.00 s (STOPPED only)
//  clear       in   1   pulse: zero the count and stop
//  digits      out  16  BCD {d3,d2,d1,d0} = tens-s, units-s, tenths, hundredths
//  running     out  1   1 while in RUN
//  at_max      out  1   1 when the count == 99.99
//  at_zero     out  1   1 when the count == 00.00
// BEHAVIOUR
//  - reset: count=0000, state=STOPPED, prescaler=0, running=0, at_max=0, at_zero=1,
//    digits=16'h0000. Reset mid-run has the same effect.
//  - Inputs are one-cycle pulses, sampled on posedge clk. Each pulse acts once.
//  - Per-cycle priority: clear > start_stop > inc/dec.
//    - inc and dec in the same cycle: no change.
//    - A lower-priority command in the same cycle as a higher one is dropped.
//  - FSM:
//    - STOPPED --start_stop & !at_max--> RUN
//    - RUN --start_stop--> STOPPED
//    - RUN --count reaches 99.99--> STOPPED (auto-stop)
//    - any --clear--> STOPPED
//    - start_stop while STOPPED and at_max: ignored.
//  - Prescaler: cleared on entry to RUN. Counts 0..TICK_DIV-1 in RUN and wraps. Tick fires when it
//    equals TICK_DIV-1, so the first increment lands TICK_DIV cycles after the start_stop edge.
//    Prescaler is frozen in STOPPED. Pause and resume restarts the partial interval.
//  - Tick: the count increments by 1 (0.01 s). BCD carry d0->d1->d2->d3, each digit wraps 9->0.
//    - On a tick that makes the count 9999: count holds at 9999 and the FSM goes to STOPPED in the
//      same cycle; running is low the next cycle.
//  - inc (STOPPED): count += 100, saturating at 9999.
//    - d1,d0 are preserved unless saturating. Example: 98.50 -> 99.50 -> 99.99.
//  - dec (STOPPED): count -= 100, clamping at 0000. Example: 00.40 -> 00.00.
//  - inc/dec in RUN: ignored.
//  - clear: count=0000, prescaler=0, state STOPPED, next cycle. Works from either state.
//  - All outputs are registered; each reflects the state one cycle after the causing edge.
//  - at_max/at_zero are derived from the registered count. A non-BCD digit never occurs.
// CONFIGURATION
//  LAP_EN defined: adds port lap (in, 1, pulse) and lap_hold (out, 1).
//    - lap in RUN toggles lap_hold.
//    - While lap_hold=1, digits shows the count latched at the lap edge; counting continues.
//    - lap in STOPPED: ignored.
//    - lap_hold is cleared by a second lap, by clear, or by reset. It is NOT cleared by stopping.
//    - lap has lowest priority; dropped if start_stop or clear occur in the same cycle.
//  LAP_EN undefined: no lap/lap_hold ports; digits always shows the live count.
// TESTING (CLK_HZ=1000, TICK_HZ=100 -> TICK_DIV=10)
//  1 reset, start_stop@c0, run 250 cycles -> digits=16'h0025, running=1; first change at c10.
//  2 STOPPED at 0000: inc x3, dec x1 -> 16'h0200; dec x5 -> 16'h0000, at_zero=1;
//    inc+dec same cycle -> unchanged.
//  3 inc to 99.00, start, 99 ticks -> 16'h9999, at_max=1, running=0;
//    start_stop -> stays STOPPED; inc -> still 9999.
//  4 RUN at 12.34: start_stop+clear same cycle -> 16'h0000, STOPPED;
//    reset mid-run -> all outputs at reset values.
//  5 RUN: start_stop at prescaler=7, wait 20 cycles, start_stop -> next increment exactly
//    10 cycles later; count frozen during pause.
//  6 (LAP_EN) RUN at 00.10: lap -> digits held 16'h0010 for 50 cycles while the internal count
//    advances; lap again -> digits=16'h0015.

Source files
------------

// File: rtl/stopwatch_counter.sv
// Stopwatch timekeeping datapath: 4-digit BCD SS.hh count driven by one-cycle command pulses.
// Define LAP_EN to add the lap/lap_hold ports that freeze the displayed value while counting continues.
module stopwatch_counter #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 100
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start_stop,
   input  logic        inc,
   input  logic        dec,
   input  logic        clear,
   output logic [15:0] digits,
   output logic        running,
   output logic        at_max,
   output logic        at_zero
`ifdef LAP_EN
   ,
   input  logic        lap,
   output logic        lap_hold
`endif
);

   localparam int TICK_DIV = CLK_HZ / TICK_HZ;
   localparam int PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

   typedef enum logic {
      STOPPED = 1'b0,
      RUN     = 1'b1
   } state_t;

   state_t        state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [15:0]   count_q, count_d;
`ifdef LAP_EN
   logic          lapHold_q, lapHold_d;
   logic [15:0]   lapCount_q, lapCount_d;
`endif

   // Add 0.01 s with decimal carry through all four digits.
   function automatic logic [15:0] tickCount(input logic [15:0] c);
      logic [15:0] r;
      logic        carry;
      r     = c;
      carry = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (carry) begin
            if (r[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      return r;
   endfunction

   function automatic logic [15:0] incSecond(input logic [15:0] c);
      logic [3:0] tens, units;
      tens  = c[15:12];
      units = c[11:8];
      if (c[15:8] == 8'h99) return 16'h9999;
      if (units == 4'd9) begin
         units = 4'd0;
         tens  = tens + 4'd1;
      end else begin
         units = units + 4'd1;
      end
      return {tens, units, c[7:0]};
   endfunction

   function automatic logic [15:0] decSecond(input logic [15:0] c);
      logic [3:0] tens, units;
      tens  = c[15:12];
      units = c[11:8];
      if (c[15:8] == 8'h00) return 16'h0000;
      if (units == 4'd0) begin
         units = 4'd9;
         tens  = tens - 4'd1;
      end else begin
         units = units - 4'd1;
      end
      return {tens, units, c[7:0]};
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= STOPPED;
         presc_q    <= '0;
         count_q    <= 16'h0000;
`ifdef LAP_EN
         lapHold_q  <= 1'b0;
         lapCount_q <= 16'h0000;
`endif
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         count_q    <= count_d;
`ifdef LAP_EN
         lapHold_q  <= lapHold_d;
         lapCount_q <= lapCount_d;
`endif
      end
   end

   // Command priority: clear, then start_stop, then inc/dec, tick and lap.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      count_d = count_q;
`ifdef LAP_EN
      lapHold_d  = lapHold_q;
      lapCount_d = lapCount_q;
`endif
      if (clear) begin
         state_d = STOPPED;
         presc_d = '0;
         count_d = 16'h0000;
`ifdef LAP_EN
         lapHold_d = 1'b0;
`endif
      end else if (start_stop) begin
         if (state_q == RUN) begin
            state_d = STOPPED;
         end else if (count_q != 16'h9999) begin
            state_d = RUN;
            presc_d = '0;
         end
      end else if (state_q == RUN) begin
         if (presc_q == PRESC_LAST) begin
            presc_d = '0;
            count_d = tickCount(count_q);
            if (count_d == 16'h9999) state_d = STOPPED;
         end else begin
            presc_d = presc_q + 1'b1;
         end
`ifdef LAP_EN
         if (lap) begin
            lapHold_d  = !lapHold_q;
            lapCount_d = count_q;
         end
`endif
      end else begin
         if (inc && !dec) count_d = incSecond(count_q);
         else if (dec && !inc) count_d = decSecond(count_q);
      end
   end

`ifdef LAP_EN
   assign digits   = lapHold_q ? lapCount_q : count_q;
   assign lap_hold = lapHold_q;
`else
   assign digits   = count_q;
`endif
   assign running = (state_q == RUN);
   assign at_max  = (count_q == 16'h9999);
   assign at_zero = (count_q == 16'h0000);

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed testbench for stopwatch_counter at CLK_HZ=1000, TICK_HZ=100 (ten cycles per 0.01 s).
// Lap checks are compiled only when LAP_EN is defined.
module tb_stopwatch_counter;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_stop, inc, dec, clear;
   logic [15:0] digits;
   logic        running, at_max, at_zero;
`ifdef LAP_EN
   logic        lap;
   logic        lap_hold;
`endif

   int totalChecks = 0;
   int badChecks   = 0;

   stopwatch_counter #(.CLK_HZ(1000), .TICK_HZ(100)) dut (
      .clk        (clk),
      .reset      (reset),
      .start_stop (start_stop),
      .inc        (inc),
      .dec        (dec),
      .clear      (clear),
      .digits     (digits),
      .running    (running),
      .at_max     (at_max),
      .at_zero    (at_zero)
`ifdef LAP_EN
      ,
      .lap        (lap),
      .lap_hold   (lap_hold)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalChecks++;
      if (observed !== expected) begin
         badChecks++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one set of command pulses for exactly one sampling edge.
   task automatic applyStimulus(input logic ss, input logic up, input logic down, input logic clr, input logic lp);
      start_stop = ss;
      inc        = up;
      dec        = down;
      clear      = clr;
`ifdef LAP_EN
      lap        = lp;
`endif
      @(posedge clk);
      #1;
      start_stop = 1'b0;
      inc        = 1'b0;
      dec        = 1'b0;
      clear      = 1'b0;
`ifdef LAP_EN
      lap        = 1'b0;
`endif
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, "_digits"}, 32'(digits), 32'h0000);
      checkOutput({tag, "_running"}, 32'(running), 32'd0);
      checkOutput({tag, "_at_max"}, 32'(at_max), 32'd0);
      checkOutput({tag, "_at_zero"}, 32'(at_zero), 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      start_stop = 1'b0; inc = 1'b0; dec = 1'b0; clear = 1'b0;
`ifdef LAP_EN
      lap = 1'b0;
`endif
      waitCycles(2);
      reset = 1'b0;
      checkResetState("reset");
`ifdef LAP_EN
      checkOutput("reset_lap_hold", 32'(lap_hold), 32'd0);
`endif

      // Run from zero: first increment ten edges after start, 0.25 s after 250 edges.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("run_running", 32'(running), 32'd1);
      waitCycles(9);
      checkOutput("run_c9", 32'(digits), 32'h0000);
      waitCycles(1);
      checkOutput("run_c10", 32'(digits), 32'h0001);
      waitCycles(240);
      checkOutput("run_c250", 32'(digits), 32'h0025);
      checkOutput("run_c250_running", 32'(running), 32'd1);

      // Pause at prescaler 7, resume: a full interval is needed for the next increment.
      waitCycles(7);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("pause_running", 32'(running), 32'd0);
      waitCycles(20);
      checkOutput("pause_frozen", 32'(digits), 32'h0025);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      waitCycles(9);
      checkOutput("resume_c9", 32'(digits), 32'h0025);
      waitCycles(1);
      checkOutput("resume_c10", 32'(digits), 32'h0026);

      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      checkResetState("clear_run");

      // Manual adjust while stopped.
      repeat (3) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("inc3", 32'(digits), 32'h0300);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("inc3_dec1", 32'(digits), 32'h0200);
      repeat (5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("dec_clamp", 32'(digits), 32'h0000);
      checkOutput("dec_clamp_zero", 32'(at_zero), 32'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      checkOutput("inc_dec_same", 32'(digits), 32'h0100);

      // Run to 12.34, inc ignored in RUN, then clear beats start_stop.
      repeat (11) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("inc_to_12", 32'(digits), 32'h1200);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      waitCycles(340);
      checkOutput("run_1234", 32'(digits), 32'h1234);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("inc_in_run", 32'(digits), 32'h1234);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      checkResetState("clear_over_ss");

      // Reset in the middle of a run.
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      waitCycles(30);
      checkOutput("pre_reset", 32'(digits), 32'h0003);
      reset = 1'b1;
      waitCycles(1);
      reset = 1'b0;
      checkResetState("reset_midrun");

      // Saturate at 99.99 and auto-stop.
      repeat (99) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("inc_to_99", 32'(digits), 32'h9900);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      waitCycles(989);
      checkOutput("run_9998", 32'(digits), 32'h9998);
      checkOutput("run_9998_running", 32'(running), 32'd1);
      waitCycles(1);
      checkOutput("max_digits", 32'(digits), 32'h9999);
      checkOutput("max_at_max", 32'(at_max), 32'd1);
      checkOutput("max_autostop", 32'(running), 32'd0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("max_ss_ignored", 32'(running), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("max_inc_sat", 32'(digits), 32'h9999);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      checkOutput("max_dec", 32'(digits), 32'h9899);
      checkOutput("max_dec_at_max", 32'(at_max), 32'd0);

`ifdef LAP_EN
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      waitCycles(100);
      checkOutput("lap_pre", 32'(digits), 32'h0010);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("lap_hold_set", 32'(lap_hold), 32'd1);
      waitCycles(49);
      checkOutput("lap_held", 32'(digits), 32'h0010);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      checkOutput("lap_release", 32'(digits), 32'h0015);
      checkOutput("lap_hold_clr", 32'(lap_hold), 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
      $finish;
   end

endmodule
